// File: rtl/matmul_pkg.sv
// Shared types and constant helpers for the matrix-multiply engine.
package matmul_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_MAC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Width needed to hold a counter/index over x values; never below one bit.
    function automatic int cnt_width(input int x);
        if (x > 1) begin
            return $clog2(x);
        end else begin
            return 1;
        end
    endfunction

    // Accumulator width large enough that a K-term dot product cannot overflow.
    function automatic int acc_width(input int dw, input int k);
        return 2 * dw + $clog2(k) + 1;
    endfunction

    // Address width covering the largest of the three RAMs.
    function automatic int addr_width(input int m, input int k, input int n);
        int mx;
        mx = m * k;
        if (k * n > mx) begin
            mx = k * n;
        end
        if (m * n > mx) begin
            mx = m * n;
        end
        return cnt_width(mx);
    endfunction

    // Clamp a value to the range representable in dw bits (signed or unsigned).
    function automatic logic [63:0] sat_to_width(input logic signed [63:0] v,
                                                 input int dw, input bit sgn);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        if (sgn) begin
            hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (dw - 1));
        end else begin
            hi = (64'sd1 <<< dw) - 64'sd1;
            lo = 64'sd0;
        end
        if (v > hi) begin
            res = hi;
        end else if (v < lo) begin
            res = lo;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/matmul_engine_sp_ram.sv
// Single-port RAM with synchronous 1-cycle read; contents are never reset.
// Addresses beyond DEPTH read as zero and never write.
module sp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    idx;
    logic             in_range;

    // Decode the storage index and whether the address lands inside the array.
    always_comb begin
        idx      = addr[IW-1:0];
        in_range = (int'(addr) < DEPTH);
    end

    // Write port.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (in_range) begin
            rdata <= mem[idx];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/matmul_engine.sv
// Self-sequencing C = A x B engine: owns operand/result RAMs, address
// generation, the MAC loop and a scaled, saturated readout path.
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 4,
    parameter int K          = 4,
    parameter int N          = 4,
    parameter bit SIGNED     = 1'b0,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K),
    parameter int AW         = addr_width(M, K, N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [AW-1:0]                wr_addr,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         rd_en,
    input  logic [AW-1:0]                rd_addr,
    input  logic [$clog2(ACC_WIDTH)-1:0] out_shift,
    output logic                         rd_valid,
    output logic [ACC_WIDTH-1:0]         rd_data,
    output logic [DATA_WIDTH-1:0]        rd_data_sc
);

    localparam int IW = cnt_width(M);
    localparam int JW = cnt_width(N);
    localparam int KW = cnt_width(K);
    // Wide enough to hold the exact product in both signed and unsigned modes.
    localparam int PW = 2 * DATA_WIDTH + 2;

    state_t state, state_nx;
    logic [IW-1:0]        i_r;
    logic [JW-1:0]        j_r;
    logic [KW-1:0]        k_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic                 busy_r, done_r, rd_valid_r, rd_oor_r;

    logic                  idle, wr_go, rd_go, last_i, last_j, last_k;
    int                    k_issue;
    logic [AW-1:0]         a_addr, b_addr, c_addr;
    logic                  a_we, b_we, c_we;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    logic [ACC_WIDTH-1:0]  c_q;

    logic signed [PW-1:0]           a_x, b_x, prod;
    logic signed [ACC_WIDTH+PW-1:0] prod_wide;
    logic [ACC_WIDTH-1:0]           prod_ext;

    logic signed [ACC_WIDTH:0] rd_x, rd_shifted;
    logic signed [63:0]        sh64;
    logic [63:0]               sat64;

    // Host access is only honoured while idle.
    always_comb begin
        idle   = (state == S_IDLE);
        wr_go  = idle && wr_en;
        rd_go  = idle && rd_en;
        last_i = (int'(i_r) == M - 1);
        last_j = (int'(j_r) == N - 1);
        last_k = (int'(k_r) == K - 1);
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FILL;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_FILL:  state_nx = S_MAC;
            S_MAC: begin
                if (last_k) begin
                    state_nx = S_WRITE;
                end else begin
                    state_nx = S_MAC;
                end
            end
            S_WRITE: begin
                if (last_i && last_j) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_FILL;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // RAM addressing: host ports while idle, otherwise the k index being
    // prefetched (0 in FILL, k+1 during MAC) one cycle ahead of its use.
    always_comb begin
        if ((state == S_MAC) && !last_k) begin
            k_issue = int'(k_r) + 1;
        end else begin
            k_issue = 0;
        end
        if (idle) begin
            a_addr = wr_addr;
            b_addr = wr_addr;
            c_addr = rd_addr;
        end else begin
            a_addr = AW'(int'(i_r) * K + k_issue);
            b_addr = AW'(k_issue * N + int'(j_r));
            c_addr = AW'(int'(i_r) * N + int'(j_r));
        end
        a_we = wr_go && !wr_sel && (int'(wr_addr) < M * K);
        b_we = wr_go &&  wr_sel && (int'(wr_addr) < K * N);
        c_we = (state == S_WRITE);
    end

    // Exact product, extended per signedness, then widened to the accumulator.
    always_comb begin
        a_x       = {{(PW - DATA_WIDTH){SIGNED && a_q[DATA_WIDTH-1]}}, a_q};
        b_x       = {{(PW - DATA_WIDTH){SIGNED && b_q[DATA_WIDTH-1]}}, b_q};
        prod      = a_x * b_x;
        prod_wide = prod;
        prod_ext  = prod_wide[ACC_WIDTH-1:0];
    end

    // FSM state, status flags and read handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_oor_r   <= 1'b0;
        end else begin
            state      <= state_nx;
            busy_r     <= (state_nx == S_FILL) || (state_nx == S_MAC) ||
                          (state_nx == S_WRITE);
            done_r     <= (state_nx == S_DONE);
            rd_valid_r <= rd_go;
            rd_oor_r   <= rd_go && (int'(rd_addr) >= M * N);
        end
    end

    // Loop counters and the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_r   <= '0;
            j_r   <= '0;
            k_r   <= '0;
            acc_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i_r <= '0;
                        j_r <= '0;
                        k_r <= '0;
                    end
                end
                S_FILL: begin
                    acc_r <= '0;
                    k_r   <= '0;
                end
                S_MAC: begin
                    acc_r <= acc_r + prod_ext;
                    if (!last_k) begin
                        k_r <= k_r + KW'(1);
                    end
                end
                S_WRITE: begin
                    if (last_j) begin
                        j_r <= '0;
                        if (last_i) begin
                            i_r <= '0;
                        end else begin
                            i_r <= i_r + IW'(1);
                        end
                    end else begin
                        j_r <= j_r + JW'(1);
                    end
                end
                default: begin
                    k_r <= '0;
                end
            endcase
        end
    end

    // Readout: the C RAM output is only exposed on a valid in-range read,
    // then shifted and saturated down to the operand width.
    always_comb begin
        if (rd_valid_r && !rd_oor_r) begin
            rd_data = c_q;
        end else begin
            rd_data = '0;
        end
        rd_x       = {SIGNED && rd_data[ACC_WIDTH-1], rd_data};
        rd_shifted = rd_x >>> out_shift;
        sh64       = rd_shifted;
        sat64      = sat_to_width(sh64, DATA_WIDTH, SIGNED);
        rd_data_sc = sat64[DATA_WIDTH-1:0];
    end

    // Drive status outputs from their registers.
    always_comb begin
        busy     = busy_r;
        done     = done_r;
        rd_valid = rd_valid_r;
    end

    sp_ram #(.WIDTH(DATA_WIDTH), .DEPTH(M * K), .AW(AW)) u_ram_a (
        .clk(clk), .we(a_we), .addr(a_addr), .wdata(wr_data), .rdata(a_q)
    );

    sp_ram #(.WIDTH(DATA_WIDTH), .DEPTH(K * N), .AW(AW)) u_ram_b (
        .clk(clk), .we(b_we), .addr(b_addr), .wdata(wr_data), .rdata(b_q)
    );

    sp_ram #(.WIDTH(ACC_WIDTH), .DEPTH(M * N), .AW(AW)) u_ram_c (
        .clk(clk), .we(c_we), .addr(c_addr), .wdata(acc_r), .rdata(c_q)
    );

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: three configurations sharing host buses,
// read results checked against a queue of expected values.
module tb_matmul_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start_v, wr_en_v, rd_en_v;
    logic       wr_sel;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data;
    logic [4:0] out_shift;
    logic [2:0] busy_v, done_v, rd_valid_v;
    logic [17:0] rd_data0;
    logic [18:0] rd_data1, rd_data2;
    logic [7:0]  sc0, sc1, sc2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_d_q [$];
    logic [7:0]  exp_s_q [$];
    int          exp_i_q [$];

    always #5 clk = ~clk;

    // 2x2x2 unsigned
    matmul_engine #(.DATA_WIDTH(8), .M(2), .K(2), .N(2), .SIGNED(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .wr_en(wr_en_v[0]), .wr_sel(wr_sel), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
        .rd_en(rd_en_v[0]), .rd_addr(rd_addr[1:0]), .out_shift(out_shift),
        .rd_valid(rd_valid_v[0]), .rd_data(rd_data0), .rd_data_sc(sc0)
    );

    // default 4x4x4 unsigned
    matmul_engine u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .wr_en(wr_en_v[1]), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en_v[1]), .rd_addr(rd_addr), .out_shift(out_shift),
        .rd_valid(rd_valid_v[1]), .rd_data(rd_data1), .rd_data_sc(sc1)
    );

    // 2x4x2 signed
    matmul_engine #(.DATA_WIDTH(8), .M(2), .K(4), .N(2), .SIGNED(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .wr_en(wr_en_v[2]), .wr_sel(wr_sel), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
        .rd_en(rd_en_v[2]), .rd_addr(rd_addr[2:0]), .out_shift(out_shift),
        .rd_valid(rd_valid_v[2]), .rd_data(rd_data2), .rd_data_sc(sc2)
    );

    function automatic logic [31:0] get_rd(input int idx);
        case (idx)
            0:       return {14'd0, rd_data0};
            1:       return {13'd0, rd_data1};
            default: return {{13{rd_data2[18]}}, rd_data2};
        endcase
    endfunction

    function automatic logic [31:0] get_sc(input int idx);
        case (idx)
            0:       return {24'd0, sc0};
            1:       return {24'd0, sc1};
            default: return {24'd0, sc2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic sel, input logic [3:0] addr, input logic [7:0] data);
        wr_en_v[idx] = 1'b1;
        wr_sel       = sel;
        wr_addr      = addr;
        wr_data      = data;
        @(posedge clk); #1;
        wr_en_v      = 3'b000;
    endtask

    task automatic fill(input int idx, input logic sel, input int cnt, input logic [7:0] data);
        for (int a = 0; a < cnt; a++) begin
            wr(idx, sel, 4'(a), data);
        end
    endtask

    // Check the result of the previous read (if any), then issue the next one.
    task automatic rd_step(input int idx, input bit en, input logic [3:0] addr,
                           input logic [31:0] ed, input logic [7:0] es);
        if (exp_i_q.size() > 0) begin
            int          pi;
            logic [31:0] pd;
            logic [7:0]  ps;
            pi = exp_i_q.pop_front();
            pd = exp_d_q.pop_front();
            ps = exp_s_q.pop_front();
            check("rd_valid", 32'(rd_valid_v[pi]), 32'd1);
            check("rd_data", get_rd(pi), pd);
            check("rd_data_sc", get_sc(pi), {24'd0, ps});
        end
        rd_en_v = 3'b000;
        if (en) begin
            rd_en_v[idx] = 1'b1;
            rd_addr      = addr;
            exp_i_q.push_back(idx);
            exp_d_q.push_back(ed);
            exp_s_q.push_back(es);
        end
        @(posedge clk); #1;
        rd_en_v = 3'b000;
    endtask

    // Start a run, optionally poking start/wr_en/rd_en at cycle inj, and time done.
    task automatic run(input int idx, input int exp_cyc, input int inj);
        int n;
        start_v[idx] = 1'b1;
        @(posedge clk); #1;
        start_v = 3'b000;
        wr_en_v = 3'b000;
        check("busy_after_start", 32'(busy_v[idx]), 32'd1);
        n = 1;
        while (done_v[idx] !== 1'b1 && n < 2000) begin
            if (n == inj) begin
                start_v[idx] = 1'b1;
                wr_en_v[idx] = 1'b1;
                wr_sel       = 1'b0;
                wr_addr      = 4'd0;
                wr_data      = 8'd0;
                rd_en_v[idx] = 1'b1;
                rd_addr      = 4'd0;
            end
            @(posedge clk); #1;
            n++;
            if (n == inj + 1) begin
                start_v = 3'b000;
                wr_en_v = 3'b000;
                rd_en_v = 3'b000;
                check("rd_valid_while_busy", 32'(rd_valid_v[idx]), 32'd0);
                check("busy_mid_run", 32'(busy_v[idx]), 32'd1);
            end
        end
        check("done_cycle", 32'(n), 32'(exp_cyc));
        check("busy_at_done", 32'(busy_v[idx]), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done_v[idx]), 32'd0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        start_v   = 3'b000;
        wr_en_v   = 3'b000;
        rd_en_v   = 3'b000;
        wr_sel    = 1'b0;
        wr_addr   = 4'd0;
        rd_addr   = 4'd0;
        wr_data   = 8'd0;
        out_shift = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_busy", 32'(busy_v[d]), 32'd0);
            check("rst_done", 32'(done_v[d]), 32'd0);
            check("rst_rd_valid", 32'(rd_valid_v[d]), 32'd0);
            check("rst_rd_data", get_rd(d), 32'd0);
            check("rst_rd_data_sc", get_sc(d), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // 2x2x2: last B element written in the same cycle as start
        wr(0, 1'b0, 4'd0, 8'd1);
        wr(0, 1'b0, 4'd1, 8'd2);
        wr(0, 1'b0, 4'd2, 8'd3);
        wr(0, 1'b0, 4'd3, 8'd4);
        wr(0, 1'b1, 4'd0, 8'd5);
        wr(0, 1'b1, 4'd1, 8'd6);
        wr(0, 1'b1, 4'd2, 8'd7);
        wr_en_v[0] = 1'b1;
        wr_sel     = 1'b1;
        wr_addr    = 4'd3;
        wr_data    = 8'd8;
        run(0, 17, -1);
        rd_step(0, 1'b1, 4'd0, 32'd19, 8'd19);
        rd_step(0, 1'b1, 4'd1, 32'd22, 8'd22);
        rd_step(0, 1'b1, 4'd2, 32'd43, 8'd43);
        rd_step(0, 1'b1, 4'd3, 32'd50, 8'd50);
        rd_step(0, 1'b0, 4'd0, 32'd0, 8'd0);

        // 4x4x4 all 255, with start/wr_en/rd_en poked mid-run
        fill(1, 1'b0, 16, 8'd255);
        fill(1, 1'b1, 16, 8'd255);
        run(1, 97, 20);
        out_shift = 5'd10;
        for (int a = 0; a < 16; a++) begin
            rd_step(1, 1'b1, 4'(a), 32'd260100, 8'd254);
        end
        rd_step(1, 1'b0, 4'd0, 32'd0, 8'd0);
        out_shift = 5'd0;
        rd_step(1, 1'b1, 4'd5, 32'd260100, 8'd255);
        rd_step(1, 1'b0, 4'd0, 32'd0, 8'd0);

        // A all 1, reset during MAC of element (1,2), then a clean rerun
        fill(1, 1'b0, 16, 8'd1);
        start_v[1] = 1'b1;
        @(posedge clk); #1;
        start_v = 3'b000;
        n = 1;
        while (n < 39) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_before_rst", 32'(busy_v[1]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("busy_after_rst", 32'(busy_v[1]), 32'd0);
        check("done_after_rst", 32'(done_v[1]), 32'd0);
        run(1, 97, -1);
        out_shift = 5'd3;
        for (int a = 0; a < 16; a++) begin
            rd_step(1, 1'b1, 4'(a), 32'd1020, 8'd127);
        end
        rd_step(1, 1'b0, 4'd0, 32'd0, 8'd0);

        // signed 2x4x2: -128 * -128, then -128 * 127, plus out-of-range read
        fill(2, 1'b0, 8, 8'h80);
        fill(2, 1'b1, 8, 8'h80);
        run(2, 25, -1);
        out_shift = 5'd0;
        for (int a = 0; a < 4; a++) begin
            rd_step(2, 1'b1, 4'(a), 32'd65536, 8'h7F);
        end
        rd_step(2, 1'b1, 4'd4, 32'd0, 8'd0);
        rd_step(2, 1'b0, 4'd0, 32'd0, 8'd0);
        fill(2, 1'b1, 8, 8'h7F);
        run(2, 25, -1);
        rd_step(2, 1'b1, 4'd0, 32'hFFFF0200, 8'h80);
        rd_step(2, 1'b1, 4'd3, 32'hFFFF0200, 8'h80);
        rd_step(2, 1'b0, 4'd0, 32'd0, 8'd0);
        out_shift = 5'd10;
        rd_step(2, 1'b1, 4'd1, 32'hFFFF0200, 8'hC0);
        rd_step(2, 1'b1, 4'd2, 32'hFFFF0200, 8'hC0);
        rd_step(2, 1'b0, 4'd0, 32'd0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
